// File: rtl/sprscan.sv
// sprscan - per-scanline sprite evaluator.
//
// At each line start this block walks all 64 sprite slots through the
// asynchronous read port of the sprite attribute RAM, decides which sprites
// cover the requested scanline and hands each hit to the line renderer over
// a valid/ready handshake. Hits leave in ascending slot order, so lower slots
// reach the renderer first and win drawing precedence.
//
// Ports:
//   clk_i, rst_ni        video clock, asynchronous active-low reset
//   line_start_i, line_i one-cycle scan request and the scanline to evaluate
//   spr_sel_o            attribute RAM read address (sprite slot)
//   spr_*_i              attributes of slot spr_sel_o, valid in the same cycle
//   out_valid_o/ready_i  hit handshake
//   out_*_o              hit payload (x, tile index, tile row, palette, flags)
//   busy_o               scan in progress (SCAN or HOLD)
//   done_o               one-cycle pulse when a scan completes normally
//   overflow_o           the last line had more than MAX_PER_LINE hits

module sprscan #(
  parameter int MAX_PER_LINE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       line_start_i,
  input  logic [7:0] line_i,
  output logic [5:0] spr_sel_o,
  input  logic [8:0] spr_x_i,
  input  logic [7:0] spr_y_i,
  input  logic [9:0] spr_idx_i,
  input  logic       spr_priority_i,
  input  logic [1:0] spr_palette_i,
  input  logic       spr_h16_i,
  input  logic       spr_vflip_i,
  input  logic       spr_hflip_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [8:0] out_x_o,
  output logic [9:0] out_idx_o,
  output logic [2:0] out_row_o,
  output logic [1:0] out_palette_o,
  output logic       out_priority_o,
  output logic       out_hflip_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       overflow_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Hit counter must reach MAX_PER_LINE, which can be as large as 64.
  localparam int CNT_W = 7;

  state_t           state_q;
  logic [5:0]       spr_sel_q;
  logic [7:0]       line_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic             done_q;
  logic             overflow_q;
  logic [8:0]       out_x_q;
  logic [9:0]       out_idx_q;
  logic [2:0]       out_row_q;
  logic [1:0]       out_palette_q;
  logic             out_priority_q;
  logic             out_hflip_q;

  logic [7:0]       dy;
  logic [7:0]       height;
  logic [3:0]       heightM1;
  logic             hit;
  logic [3:0]       row_d;
  logic [9:0]       idx_d;
  logic             lastSlot;
  logic             countFull;

  // Vertical intersection test for the slot currently on the RAM read port.
  // The subtraction wraps mod 256, so a sprite whose top sits near line 255
  // naturally covers the first lines of the next frame area. For a vertically
  // flipped sprite the row counts back from the bottom; a 16-line sprite is
  // two stacked 8-row tiles, and the lower tile is the next tile index.
  always_comb begin
    dy        = line_q - spr_y_i;
    height    = spr_h16_i ? 8'd16 : 8'd8;
    heightM1  = spr_h16_i ? 4'd15 : 4'd7;
    hit       = (dy < height);
    row_d     = spr_vflip_i ? (heightM1 - dy[3:0]) : dy[3:0];
    idx_d     = spr_idx_i + {9'd0, spr_h16_i & row_d[3]};
    lastSlot  = (spr_sel_q == 6'd63);
    countFull = (cnt_q == CNT_W'(MAX_PER_LINE));
  end

  // Scan sequencer. A line_start in any state restarts the scan from slot 0,
  // which also abandons a pending hit without a done pulse. done is only
  // raised on the transition into FIN, so it lasts exactly one cycle and can
  // never coincide with out_valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      spr_sel_q      <= 6'd0;
      line_q         <= 8'd0;
      cnt_q          <= '0;
      out_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
      out_x_q        <= 9'd0;
      out_idx_q      <= 10'd0;
      out_row_q      <= 3'd0;
      out_palette_q  <= 2'd0;
      out_priority_q <= 1'b0;
      out_hflip_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (line_start_i) begin
        line_q      <= line_i;
        spr_sel_q   <= 6'd0;
        cnt_q       <= '0;
        overflow_q  <= 1'b0;
        out_valid_q <= 1'b0;
        state_q     <= SCAN;
      end else begin
        case (state_q)
          IDLE: begin
          end
          SCAN: begin
            if (!hit) begin
              if (lastSlot) begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end else begin
                spr_sel_q <= spr_sel_q + 6'd1;
              end
            end else if (countFull) begin
              // Budget exhausted: remaining slots are left unvisited.
              overflow_q <= 1'b1;
              state_q    <= FIN;
              done_q     <= 1'b1;
            end else begin
              out_x_q        <= spr_x_i;
              out_idx_q      <= idx_d;
              out_row_q      <= row_d[2:0];
              out_palette_q  <= spr_palette_i;
              out_priority_q <= spr_priority_i;
              out_hflip_q    <= spr_hflip_i;
              out_valid_q    <= 1'b1;
              state_q        <= HOLD;
            end
          end
          HOLD: begin
            if (out_ready_i) begin
              out_valid_q <= 1'b0;
              cnt_q       <= cnt_q + CNT_W'(1);
              if (lastSlot) begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end else begin
                spr_sel_q <= spr_sel_q + 6'd1;
                state_q   <= SCAN;
              end
            end
          end
          FIN: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign spr_sel_o      = spr_sel_q;
  assign out_valid_o    = out_valid_q;
  assign out_x_o        = out_x_q;
  assign out_idx_o      = out_idx_q;
  assign out_row_o      = out_row_q;
  assign out_palette_o  = out_palette_q;
  assign out_priority_o = out_priority_q;
  assign out_hflip_o    = out_hflip_q;
  assign busy_o         = (state_q == SCAN) || (state_q == HOLD);
  assign done_o         = done_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_sprscan.sv
// tb_sprscan - directed testbench for sprscan.
//
// A small attribute RAM model answers spr_sel combinationally. Each scenario
// loads the slot table, fires a line_start and follows the scan cycle by
// cycle, recording every handshaken hit and the cycle where done appears.

module tb_sprscan;

  logic       clk;
  logic       rstN;
  logic       lineStart;
  logic [7:0] lineNum;
  logic [5:0] sprSel;
  logic       outValid;
  logic       outReady;
  logic [8:0] outX;
  logic [9:0] outIdx;
  logic [2:0] outRow;
  logic [1:0] outPalette;
  logic       outPriority;
  logic       outHflip;
  logic       busy;
  logic       done;
  logic       overflow;

  logic [8:0] ramX   [64];
  logic [7:0] ramY   [64];
  logic [9:0] ramIdx [64];
  logic       ramPri [64];
  logic [1:0] ramPal [64];
  logic       ramH16 [64];
  logic       ramVfl [64];
  logic       ramHfl [64];

  int testsRun;
  int testsFailed;

  int hitCount;
  int hitSlot [64];
  int hitX    [64];
  int hitIdx  [64];
  int hitRow  [64];
  int doneCycle;
  int overlapCount;

  sprscan #(.MAX_PER_LINE(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .line_start_i   (lineStart),
    .line_i         (lineNum),
    .spr_sel_o      (sprSel),
    .spr_x_i        (ramX[sprSel]),
    .spr_y_i        (ramY[sprSel]),
    .spr_idx_i      (ramIdx[sprSel]),
    .spr_priority_i (ramPri[sprSel]),
    .spr_palette_i  (ramPal[sprSel]),
    .spr_h16_i      (ramH16[sprSel]),
    .spr_vflip_i    (ramVfl[sprSel]),
    .spr_hflip_i    (ramHfl[sprSel]),
    .out_valid_o    (outValid),
    .out_ready_i    (outReady),
    .out_x_o        (outX),
    .out_idx_o      (outIdx),
    .out_row_o      (outRow),
    .out_palette_o  (outPalette),
    .out_priority_o (outPriority),
    .out_hflip_o    (outHflip),
    .busy_o         (busy),
    .done_o         (done),
    .overflow_o     (overflow)
  );

  // Free-running 10 ns video clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load every slot as an off-screen sprite (y=200 never covers lines used).
  task automatic clearTable();
    for (int i = 0; i < 64; i++) begin
      ramX[i]   = 9'd0;
      ramY[i]   = 8'd200;
      ramIdx[i] = 10'd0;
      ramPri[i] = 1'b0;
      ramPal[i] = 2'd0;
      ramH16[i] = 1'b0;
      ramVfl[i] = 1'b0;
      ramHfl[i] = 1'b0;
    end
  endtask

  // Table with a single 8-line sprite at slot 3, y=10, x=100, idx=0x20.
  task automatic loadSlot3();
    clearTable();
    ramY[3]   = 8'd10;
    ramX[3]   = 9'd100;
    ramIdx[3] = 10'h020;
    ramPal[3] = 2'd2;
    ramPri[3] = 1'b1;
  endtask

  // Pulse line_start for one cycle; on return the DUT is in cycle 1.
  task automatic applyStimulus(input logic [7:0] l);
    lineStart = 1'b1;
    lineNum   = l;
    tick();
    lineStart = 1'b0;
  endtask

  // Follow the scan from cycle startCycle until done or the budget runs out,
  // logging each accepted hit.
  task automatic runLine(input int startCycle);
    int  c;
    bit  finished;
    c            = startCycle;
    finished     = 1'b0;
    hitCount     = 0;
    doneCycle    = -1;
    overlapCount = 0;
    while (!finished && c < startCycle + 200) begin
      if (done && outValid) overlapCount++;
      if (outValid && outReady && hitCount < 64) begin
        hitSlot[hitCount] = int'(sprSel);
        hitX[hitCount]    = int'(outX);
        hitIdx[hitCount]  = int'(outIdx);
        hitRow[hitCount]  = int'(outRow);
        hitCount++;
      end
      if (done) begin
        doneCycle = c;
        finished  = 1'b1;
      end else begin
        tick();
        c++;
      end
    end
    if (!finished) checkOutput("scanTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [8:0] heldX;
    logic [9:0] heldIdx;
    logic [5:0] heldSel;

    testsRun    = 0;
    testsFailed = 0;
    rstN        = 1'b0;
    lineStart   = 1'b0;
    lineNum     = 8'd0;
    outReady    = 1'b0;
    clearTable();

    // Reset state.
    #12;
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstSel", 32'(sprSel), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    rstN = 1'b1;
    tick();

    // Reset while holding a hit: everything clears immediately.
    loadSlot3();
    outReady = 1'b0;
    applyStimulus(8'd12);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("holdValidBeforeReset", 32'(outValid), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(outValid), 32'd0);
    checkOutput("asyncRstSel", 32'(sprSel), 32'd0);
    checkOutput("asyncRstBusy", 32'(busy), 32'd0);
    checkOutput("asyncRstX", 32'(outX), 32'd0);
    #2;
    rstN = 1'b1;
    tick();
    checkOutput("postRstIdle", 32'(busy), 32'd0);
    outReady = 1'b1;
    applyStimulus(8'd5);
    checkOutput("rescanSel", 32'(sprSel), 32'd0);
    checkOutput("rescanBusy", 32'(busy), 32'd1);
    runLine(1);
    checkOutput("line5Hits", 32'(hitCount), 32'd0);
    checkOutput("line5Done", 32'(doneCycle), 32'd65);
    tick();

    // Single hit at slot 3 with the renderer always ready.
    loadSlot3();
    outReady = 1'b1;
    applyStimulus(8'd12);
    runLine(1);
    checkOutput("oneHitCount", 32'(hitCount), 32'd1);
    checkOutput("oneHitSlot", 32'(hitSlot[0]), 32'd3);
    checkOutput("oneHitX", 32'(hitX[0]), 32'd100);
    checkOutput("oneHitIdx", 32'(hitIdx[0]), 32'h20);
    checkOutput("oneHitRow", 32'(hitRow[0]), 32'd2);
    checkOutput("oneHitDone", 32'(doneCycle), 32'd66);
    checkOutput("oneHitOverlap", 32'(overlapCount), 32'd0);
    tick();
    checkOutput("doneOneCycle", 32'(done), 32'd0);

    // 16-line vflipped sprite wrapping through line 0 and the tile index.
    clearTable();
    ramY[0]   = 8'd250;
    ramH16[0] = 1'b1;
    ramVfl[0] = 1'b1;
    ramIdx[0] = 10'h3FF;
    applyStimulus(8'd4);
    runLine(1);
    checkOutput("vflipHits", 32'(hitCount), 32'd1);
    checkOutput("vflipIdxA", 32'(hitIdx[0]), 32'h3FF);
    checkOutput("vflipRowA", 32'(hitRow[0]), 32'd5);
    tick();
    applyStimulus(8'd251);
    runLine(1);
    checkOutput("vflipIdxB", 32'(hitIdx[0]), 32'h000);
    checkOutput("vflipRowB", 32'(hitRow[0]), 32'd6);
    checkOutput("vflipDoneB", 32'(doneCycle), 32'd66);
    tick();

    // Every slot covers line 0: only 16 hits leave, then overflow.
    clearTable();
    for (int i = 0; i < 64; i++) begin
      ramY[i]   = 8'd0;
      ramX[i]   = 9'(i);
      ramIdx[i] = 10'(i);
    end
    applyStimulus(8'd0);
    runLine(1);
    checkOutput("ovfHits", 32'(hitCount), 32'd16);
    checkOutput("ovfFirstSlot", 32'(hitSlot[0]), 32'd0);
    checkOutput("ovfLastSlot", 32'(hitSlot[15]), 32'd15);
    checkOutput("ovfLastX", 32'(hitX[15]), 32'd15);
    checkOutput("ovfDone", 32'(doneCycle), 32'd34);
    checkOutput("ovfFlag", 32'(overflow), 32'd1);
    checkOutput("ovfStopSel", 32'(sprSel), 32'd16);
    tick();
    checkOutput("ovfHeld", 32'(overflow), 32'd1);

    // A fresh line clears overflow.
    loadSlot3();
    applyStimulus(8'd12);
    checkOutput("ovfCleared", 32'(overflow), 32'd0);
    runLine(1);
    checkOutput("ovfClearHits", 32'(hitCount), 32'd1);
    tick();

    // Backpressure: hit held for 5 cycles with the renderer stalled.
    loadSlot3();
    outReady = 1'b0;
    applyStimulus(8'd12);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("bpNotYetValid", 32'(outValid), 32'd0);
    tick();
    checkOutput("bpValidCycle5", 32'(outValid), 32'd1);
    heldX   = outX;
    heldIdx = outIdx;
    heldSel = sprSel;
    checkOutput("bpHeldX", 32'(heldX), 32'd100);
    checkOutput("bpHeldSel", 32'(heldSel), 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("bpStableValid", 32'(outValid), 32'd1);
      checkOutput("bpStableX", 32'(outX), 32'd100);
      checkOutput("bpStableIdx", 32'(outIdx), 32'h20);
      checkOutput("bpStableSel", 32'(sprSel), 32'd3);
    end
    outReady = 1'b1;
    runLine(9);
    checkOutput("bpHits", 32'(hitCount), 32'd1);
    checkOutput("bpDone", 32'(doneCycle), 32'd70);
    tick();

    // Abort from HOLD with a new line_start.
    loadSlot3();
    outReady = 1'b0;
    applyStimulus(8'd12);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("abortHoldValid", 32'(outValid), 32'd1);
    applyStimulus(8'd7);
    checkOutput("abortValid", 32'(outValid), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    checkOutput("abortSel", 32'(sprSel), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd1);
    outReady = 1'b1;
    runLine(1);
    checkOutput("abortHits", 32'(hitCount), 32'd0);
    checkOutput("abortDoneCycle", 32'(doneCycle), 32'd65);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
